spice_clock_sequencer: RTL and testbench

//  Sequences the emulated chip clock for the transistor-level netlist model. Each chip

---
 rtl/spice_clock_sequencer_pkg.sv | 25 ++
 rtl/spice_clock_sequencer_settle_timer.sv | 45 ++++
 rtl/spice_clock_sequencer.sv | 131 +++++++++++++
 tb/tb_spice_clock_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spice_clock_sequencer_pkg.sv
// Shared state encoding, minimum settle length and the half-cycle length
// selection used by the spice clock sequencer.
package spice_clock_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RES_HOLD = 2'd0,
        ST_RUN      = 2'd1,
        ST_HALT     = 2'd2,
        ST_STEP     = 2'd3
    } seq_state_e;

    // spice_latch gates need at least this many stable eclk per half-cycle
    localparam logic [7:0] MIN_SETTLE = 8'd4;

    function automatic logic [7:0] settle_len(input logic [7:0] cfg, input logic [7:0] dflt);
        if (cfg == 8'd0) begin
            return dflt;
        end else if (cfg < MIN_SETTLE) begin
            return MIN_SETTLE;
        end else begin
            return cfg;
        end
    endfunction

endpackage

// File: rtl/spice_clock_sequencer_settle_timer.sv
// spice_settle_timer: latches the half-cycle length L on the first eclk of a
// half-cycle, counts L eclk and pulses term_o on the last one.
module spice_settle_timer
    import spice_clock_sequencer_pkg::*;
#(
    parameter int unsigned SETTLE_DEFAULT = 16
) (
    input  logic       eclk,
    input  logic       ereset_n,
    input  logic       en_i,
    input  logic [7:0] cfg_settle_i,
    output logic       term_o
);

    logic [7:0] cnt_q, cnt_d;
    logic [7:0] len_q, len_d;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        len_d  = len_q;
        cnt_d  = cnt_q;
        term_o = 1'b0;
        if (en_i) begin
            if (cnt_q == 8'd0) begin
                len_d = settle_len(cfg_settle_i, 8'(SETTLE_DEFAULT));
            end
            term_o = (cnt_q == len_d - 8'd1);
            cnt_d  = term_o ? 8'd0 : cnt_q + 8'd1;
        end else begin
            cnt_d = 8'd0;
        end
    end

    always_ff @(posedge eclk) begin
        // NOTE: registered state is only ever updated with non-blocking assignments.
        if (!ereset_n) begin
            cnt_q <= '0;
            len_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            len_q <= len_d;
        end
    end

endmodule

// File: rtl/spice_clock_sequencer.sv
// spice_clock_sequencer: chip clock/reset sequencing with run/halt and step handshake.
// Optional breakpoint halting is enabled by defining SPICE_SEQ_BREAKPOINT_EN.
module spice_clock_sequencer
    import spice_clock_sequencer_pkg::*;
#(
    parameter int unsigned SETTLE_DEFAULT  = 16,
    parameter int unsigned RES_HALF_CYCLES = 12,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             eclk,
    input  logic             ereset_n,
    input  logic             run,
    input  logic             step_req,
    output logic             step_ack,
    input  logic [7:0]       cfg_settle,
    input  logic             bp_en,
    input  logic [CNT_W-1:0] bp_count,
    output logic             phi0,
    output logic             chip_res_n,
    output logic             phi_edge,
    output logic             halted,
    output logic             bp_hit,
    output logic [CNT_W-1:0] half_count
);

    localparam int unsigned RES_W = $clog2(RES_HALF_CYCLES + 1);

    seq_state_e       state_q;
    logic             phi0_q, chip_res_n_q, phi_edge_q, halted_q, step_ack_q, bp_hit_q, rearm_q;
    logic [CNT_W-1:0] half_count_q;
    logic [CNT_W-1:0] hc_inc;
    logic [RES_W-1:0] res_cnt_q;
    logic             term;

    assign hc_inc = half_count_q + CNT_W'(1);

    spice_settle_timer #(
        .SETTLE_DEFAULT(SETTLE_DEFAULT)
    ) u_timer (
        .eclk        (eclk),
        .ereset_n    (ereset_n),
        .en_i        (state_q != ST_HALT),
        .cfg_settle_i(cfg_settle),
        .term_o      (term)
    );

`ifndef SPICE_SEQ_BREAKPOINT_EN
    logic unused_bp;
    assign unused_bp = bp_en ^ (^bp_count);
`endif

    always_ff @(posedge eclk) begin
        if (!ereset_n) begin
            state_q      <= ST_RES_HOLD;
            phi0_q       <= 1'b0;
            chip_res_n_q <= 1'b0;
            phi_edge_q   <= 1'b0;
            halted_q     <= 1'b0;
            step_ack_q   <= 1'b0;
            bp_hit_q     <= 1'b0;
            rearm_q      <= 1'b0;
            half_count_q <= '0;
            res_cnt_q    <= '0;
        end else begin
            phi_edge_q <= term;
            if (term) phi0_q <= ~phi0_q;
            if (step_ack_q && !step_req) step_ack_q <= 1'b0;

            case (state_q)
                ST_RES_HOLD: begin
                    if (term) begin
                        if (res_cnt_q == RES_W'(RES_HALF_CYCLES - 1)) begin
                            chip_res_n_q <= 1'b1;
                            state_q      <= run ? ST_RUN : ST_HALT;
                            halted_q     <= !run;
                        end else begin
                            res_cnt_q <= res_cnt_q + RES_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    // run is only sampled at the edge so a half-cycle is never cut short
                    if (term) begin
                        half_count_q <= hc_inc;
`ifdef SPICE_SEQ_BREAKPOINT_EN
                        if (bp_en && hc_inc == bp_count) begin
                            state_q  <= ST_HALT;
                            halted_q <= 1'b1;
                            bp_hit_q <= 1'b1;
                            rearm_q  <= 1'b1;
                        end else
`endif
                        if (!run) begin
                            state_q  <= ST_HALT;
                            halted_q <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    if (!run) rearm_q <= 1'b0;
                    if (run && !rearm_q) begin
                        state_q  <= ST_RUN;
                        halted_q <= 1'b0;
                        bp_hit_q <= 1'b0;
                    end else if (step_req && !step_ack_q && !run) begin
                        state_q  <= ST_STEP;
                        halted_q <= 1'b0;
                        bp_hit_q <= 1'b0;
                    end
                end
                ST_STEP: begin
                    if (term) begin
                        half_count_q <= hc_inc;
                        step_ack_q   <= 1'b1;
                        state_q      <= ST_HALT;
                        halted_q     <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign phi0       = phi0_q;
    assign chip_res_n = chip_res_n_q;
    assign phi_edge   = phi_edge_q;
    assign halted     = halted_q;
    assign step_ack   = step_ack_q;
    assign bp_hit     = bp_hit_q;
    assign half_count = half_count_q;

endmodule

// File: tb/tb_spice_clock_sequencer.sv
// Directed bench for spice_clock_sequencer: a default-width instance plus a
// CNT_W=4 instance for the half_count wrap.
module tb_spice_clock_sequencer;

    logic        eclk;
    logic        ereset_n, run, step_req, bp_en;
    logic [7:0]  cfg_settle;
    logic [31:0] bp_count;
    logic        step_ack, phi0, chip_res_n, phi_edge, halted, bp_hit;
    logic [31:0] half_count;

    logic        w_rst_n;
    logic        w_step_ack, w_phi0, w_chip_res_n, w_phi_edge, w_halted, w_bp_hit;
    logic [3:0]  w_half_count;

    int          total;
    int          bad;
    logic [31:0] exp_hc;
    logic        exp_phi;

    spice_clock_sequencer u_dut (
        .eclk(eclk), .ereset_n(ereset_n), .run(run), .step_req(step_req), .step_ack(step_ack),
        .cfg_settle(cfg_settle), .bp_en(bp_en), .bp_count(bp_count), .phi0(phi0),
        .chip_res_n(chip_res_n), .phi_edge(phi_edge), .halted(halted), .bp_hit(bp_hit),
        .half_count(half_count)
    );

    spice_clock_sequencer #(.CNT_W(4)) u_wrap (
        .eclk(eclk), .ereset_n(w_rst_n), .run(1'b1), .step_req(1'b0), .step_ack(w_step_ack),
        .cfg_settle(8'd2), .bp_en(1'b0), .bp_count(4'd0), .phi0(w_phi0),
        .chip_res_n(w_chip_res_n), .phi_edge(w_phi_edge), .halted(w_halted), .bp_hit(w_bp_hit),
        .half_count(w_half_count)
    );

    initial eclk = 1'b0;
    always #5 eclk = ~eclk;

    task automatic tick(input int k);
        repeat (k) @(negedge eclk);
    endtask

    // Returns the number of eclk until phi_edge is seen, bounded by max_cyc.
    task automatic wait_edge(input bit on_wrap, input int max_cyc, output int n);
        n = 0;
        do begin
            @(negedge eclk);
            n++;
        end while (!(on_wrap ? w_phi_edge : phi_edge) && n < max_cyc);
    endtask

    task automatic test_reset();
        ereset_n = 1'b0; w_rst_n = 1'b0; run = 1'b1; step_req = 1'b0;
        cfg_settle = 8'd0; bp_en = 1'b0; bp_count = 32'd0;
        tick(3);
        total++; if (phi0 !== 1'b0) begin bad++; $display("FAIL reset_phi0: got %b want 0", phi0); end
        total++; if (chip_res_n !== 1'b0) begin bad++; $display("FAIL reset_chip_res_n: got %b want 0", chip_res_n); end
        total++; if ({phi_edge, halted, step_ack, bp_hit} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got %b want 0000", {phi_edge, halted, step_ack, bp_hit});
        end
        total++; if (half_count !== 32'd0) begin bad++; $display("FAIL reset_half_count: got %0d want 0", half_count); end
    endtask

    task automatic test_res_hold();
        int n;
        ereset_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            wait_edge(1'b0, 64, n);
            total++; if (n !== 16) begin bad++; $display("FAIL res_hold_len[%0d]: got %0d want 16", i, n); end
            if (i == 11) begin
                total++; if (chip_res_n !== 1'b0) begin bad++; $display("FAIL res_n_early: got %b want 0", chip_res_n); end
            end
        end
        total++; if (chip_res_n !== 1'b1) begin bad++; $display("FAIL res_n_release: got %b want 1", chip_res_n); end
        total++; if (half_count !== 32'd0) begin bad++; $display("FAIL res_hold_count: got %0d want 0", half_count); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL res_hold_halted: got %b want 0", halted); end
        exp_hc = 32'd0; exp_phi = 1'b0;
        n = 0;
        for (int i = 0; i < 2; i++) begin
            int m;
            wait_edge(1'b0, 64, m);
            n += m;
            exp_hc++; exp_phi = ~exp_phi;
        end
        total++; if (n !== 32) begin bad++; $display("FAIL phi0_period: got %0d want 32", n); end
        total++; if (half_count !== exp_hc) begin bad++; $display("FAIL run_count: got %0d want %0d", half_count, exp_hc); end
        total++; if (phi0 !== exp_phi) begin bad++; $display("FAIL run_phi0: got %b want %b", phi0, exp_phi); end
    endtask

    task automatic test_settle_clamp();
        logic [7:0] cfg_tab [5] = '{8'd2, 8'd3, 8'd5, 8'd1, 8'd0};
        int         len_tab [5] = '{4, 4, 5, 4, 16};
        int         n;
        for (int i = 0; i < 5; i++) begin
            cfg_settle = cfg_tab[i];
            wait_edge(1'b0, 64, n);
            exp_hc++; exp_phi = ~exp_phi;
            total++; if (n !== len_tab[i]) begin
                bad++; $display("FAIL settle_len cfg=%0d: got %0d want %0d", cfg_tab[i], n, len_tab[i]);
            end
        end
        total++; if (half_count !== exp_hc) begin bad++; $display("FAIL settle_count: got %0d want %0d", half_count, exp_hc); end
    endtask

    task automatic test_mid_change();
        int n;
        cfg_settle = 8'd10;
        tick(3);
        cfg_settle = 8'd20;
        wait_edge(1'b0, 64, n);
        exp_hc++; exp_phi = ~exp_phi;
        total++; if (n !== 7) begin bad++; $display("FAIL mid_change_first: got %0d want 7", n); end
        tick(1);
        cfg_settle = 8'd0;
        wait_edge(1'b0, 64, n);
        exp_hc++; exp_phi = ~exp_phi;
        total++; if (n !== 19) begin bad++; $display("FAIL mid_change_second: got %0d want 19", n); end
        total++; if (phi0 !== exp_phi) begin bad++; $display("FAIL mid_change_phi0: got %b want %b", phi0, exp_phi); end
    endtask

    task automatic test_run_drop();
        int n, edges;
        tick(3);
        run = 1'b0;
        wait_edge(1'b0, 64, n);
        exp_hc++; exp_phi = ~exp_phi;
        total++; if (n !== 13) begin bad++; $display("FAIL run_drop_len: got %0d want 13", n); end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL run_drop_halted: got %b want 1", halted); end
        total++; if (half_count !== exp_hc) begin bad++; $display("FAIL run_drop_count: got %0d want %0d", half_count, exp_hc); end
        edges = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (phi_edge) edges++;
        end
        total++; if (edges !== 0) begin bad++; $display("FAIL halt_frozen_edges: got %0d want 0", edges); end
        total++; if (phi0 !== exp_phi) begin bad++; $display("FAIL halt_frozen_phi0: got %b want %b", phi0, exp_phi); end
    endtask

    task automatic test_step();
        int n, edges;
        step_req = 1'b1;
        // one eclk to leave HALT, then a full 16-eclk half-cycle
        wait_edge(1'b0, 64, n);
        exp_hc++; exp_phi = ~exp_phi;
        total++; if (n !== 17) begin bad++; $display("FAIL step_len: got %0d want 17", n); end
        total++; if ({step_ack, halted} !== 2'b11) begin bad++; $display("FAIL step_ack_halted: got %b want 11", {step_ack, halted}); end
        total++; if (half_count !== exp_hc) begin bad++; $display("FAIL step_count: got %0d want %0d", half_count, exp_hc); end
        total++; if (phi0 !== exp_phi) begin bad++; $display("FAIL step_phi0: got %b want %b", phi0, exp_phi); end
        edges = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (phi_edge) edges++;
        end
        total++; if (edges !== 0) begin bad++; $display("FAIL step_single: got %0d edges want 0", edges); end
        total++; if (step_ack !== 1'b1) begin bad++; $display("FAIL step_ack_hold: got %b want 1", step_ack); end
        step_req = 1'b0;
        tick(1);
        total++; if (step_ack !== 1'b0) begin bad++; $display("FAIL step_ack_clear: got %b want 0", step_ack); end
        run = 1'b1; step_req = 1'b1;
        tick(1);
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL run_wins_halted: got %b want 0", halted); end
        wait_edge(1'b0, 64, n);
        exp_hc++; exp_phi = ~exp_phi;
        total++; if (n !== 16) begin bad++; $display("FAIL run_wins_len: got %0d want 16", n); end
        total++; if ({step_ack, halted} !== 2'b00) begin bad++; $display("FAIL run_wins_flags: got %b want 00", {step_ack, halted}); end
        total++; if (half_count !== exp_hc) begin bad++; $display("FAIL run_wins_count: got %0d want %0d", half_count, exp_hc); end
        step_req = 1'b0;
    endtask

    task automatic test_mid_reset();
        int n;
        wait_edge(1'b0, 64, n);
        exp_hc++; exp_phi = ~exp_phi;
        total++; if ({phi0, half_count} !== {exp_phi, exp_hc}) begin
            bad++; $display("FAIL pre_reset: got phi0=%b cnt=%0d want phi0=%b cnt=%0d", phi0, half_count, exp_phi, exp_hc);
        end
        tick(5);
        ereset_n = 1'b0;
        tick(1);
        total++; if ({phi0, chip_res_n, phi_edge, halted, step_ack, bp_hit} !== 6'b000000) begin
            bad++; $display("FAIL mid_reset_flags: got %b want 000000", {phi0, chip_res_n, phi_edge, halted, step_ack, bp_hit});
        end
        total++; if (half_count !== 32'd0) begin bad++; $display("FAIL mid_reset_count: got %0d want 0", half_count); end
        ereset_n = 1'b1;
        wait_edge(1'b0, 64, n);
        total++; if (n !== 16) begin bad++; $display("FAIL post_reset_len: got %0d want 16", n); end
        total++; if (chip_res_n !== 1'b0) begin bad++; $display("FAIL post_reset_hold: got %b want 0", chip_res_n); end
    endtask

    task automatic test_breakpoint();
        int n, sum, edges;
        ereset_n = 1'b0;
        tick(2);
        cfg_settle = 8'd2; run = 1'b1; bp_en = 1'b1; bp_count = 32'd5;
        ereset_n = 1'b1;
        sum = 0;
        for (int i = 0; i < 12; i++) begin
            wait_edge(1'b0, 64, n);
            sum += n;
        end
        total++; if (sum !== 48 || chip_res_n !== 1'b1) begin
            bad++; $display("FAIL bp_res_hold: got %0d eclk res_n=%b want 48 res_n=1", sum, chip_res_n);
        end
`ifdef SPICE_SEQ_BREAKPOINT_EN
        for (int i = 0; i < 5; i++) wait_edge(1'b0, 64, n);
        total++; if ({halted, bp_hit} !== 2'b11) begin bad++; $display("FAIL bp_halt: got %b want 11", {halted, bp_hit}); end
        total++; if (half_count !== 32'd5) begin bad++; $display("FAIL bp_count_val: got %0d want 5", half_count); end
        edges = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (phi_edge) edges++;
        end
        total++; if (edges !== 0 || halted !== 1'b1) begin
            bad++; $display("FAIL bp_rearm_hold: got edges=%0d halted=%b want 0 1", edges, halted);
        end
        run = 1'b0;
        tick(2);
        run = 1'b1;
        tick(1);
        total++; if ({halted, bp_hit} !== 2'b00) begin bad++; $display("FAIL bp_resume: got %b want 00", {halted, bp_hit}); end
        wait_edge(1'b0, 64, n);
        total++; if (n !== 4 || half_count !== 32'd6) begin
            bad++; $display("FAIL bp_after: got len=%0d cnt=%0d want 4 6", n, half_count);
        end
`else
        edges = 0;
        for (int i = 0; i < 6; i++) begin
            wait_edge(1'b0, 64, n);
            if (n == 4) edges++;
        end
        total++; if (edges !== 6) begin bad++; $display("FAIL bp_ignored_len: got %0d good edges want 6", edges); end
        total++; if ({halted, bp_hit} !== 2'b00) begin bad++; $display("FAIL bp_ignored_flags: got %b want 00", {halted, bp_hit}); end
        total++; if (half_count !== 32'd6) begin bad++; $display("FAIL bp_ignored_count: got %0d want 6", half_count); end
`endif
        bp_en = 1'b0;
    endtask

    task automatic test_wrap();
        int n;
        w_rst_n = 1'b1;
        for (int i = 0; i < 12; i++) wait_edge(1'b1, 64, n);
        total++; if (w_chip_res_n !== 1'b1) begin bad++; $display("FAIL wrap_res_n: got %b want 1", w_chip_res_n); end
        for (int i = 0; i < 15; i++) wait_edge(1'b1, 64, n);
        total++; if (w_half_count !== 4'd15) begin bad++; $display("FAIL wrap_pre: got %0d want 15", w_half_count); end
        wait_edge(1'b1, 64, n);
        total++; if (w_half_count !== 4'd0) begin bad++; $display("FAIL wrap_post: got %0d want 0", w_half_count); end
        total++; if (n !== 4) begin bad++; $display("FAIL wrap_len: got %0d want 4", n); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_res_hold();
        test_settle_clamp();
        test_mid_change();
        test_run_drop();
        test_step();
        test_mid_reset();
        test_breakpoint();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
